noc_flit_fifo: RTL
==================

Name: noc_flit_fifo

Overview:
Parametrised input-port flit FIFO for the 5-port NoC router; one instance per router input port. It replaces the fixed 16-bit, 5-entry buffer with configurable data width and depth. It adds true simultaneous read/write, an almost-full threshold for upstream flow control, an occupancy count, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.

Parameters:
DATA_W, 16, flit width in bits
DEPTH, 5, number of storage entries; any integer >= 2, not restricted to powers of two
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
FWFT, 0, 0 = registered read (data one cycle after rd_en); 1 = head entry visible on rd_data while not empty
CNT_W, $clog2(DEPTH+1), width of the count output; derived, never overridden

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  push request
wr_data  in  DATA_W  flit to push
rd_en  in  1  pop request
rd_data  out  DATA_W  popped flit (FWFT=0) or head flit (FWFT=1)
rd_valid  out  1  FWFT=0: one-cycle pulse, rd_data valid this cycle; FWFT=1: equals !empty
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
empty  out  1  count == 0
count  out  CNT_W  current occupancy, 0..DEPTH
overflow  out  1  sticky: a push was attempted while full and no pop was accepted
underflow  out  1  sticky: a pop was attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset, asynchronous on rst_n low: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. The storage array is not reset.
- full, almost_full and empty are decoded combinationally from registered count. Reset values: empty=1, full=0, almost_full=0.
- Pops: pop_ok = rd_en && !empty, evaluated on pre-edge state.
- Pushes: push_ok = wr_en && (!full || pop_ok).
- Pointers wrap explicitly: value DEPTH-1 + 1 becomes 0. Modulo-2^n wrap is not used.
- count update: count + push_ok - pop_ok, evaluated each cycle.
- Simultaneous push and pop, not empty: both are accepted and count is unchanged. This includes the full case, where the pop frees a slot and the push fills it in the same cycle.
- Simultaneous push and pop, empty: the push is accepted and the pop is rejected. underflow sets and count becomes 1. There is no same-cycle bypass from wr_data to rd_data.
- Push while full with no pop_ok: data is dropped, pointers hold, overflow sets.
- Pop while empty: pointers hold, underflow sets. In FWFT=0 mode rd_valid stays 0 and rd_data holds.
- FWFT=0 read: on pop_ok, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the same edge. Data is therefore usable in the cycle after rd_en. rd_valid deasserts on the next cycle with no pop_ok, and rd_data holds its last value.
- FWFT=1 read: rd_data = mem[rd_ptr], combinational from the array. rd_valid = !empty. rd_en acknowledges the head and advances rd_ptr. A pushed flit first appears on rd_data in the cycle after the push edge.
- Error flags: overflow and underflow hold until clr_err=1 at a clock edge or until reset. If clr_err and a new error occur in the same cycle, the flag ends set (set wins).
- Reset asserted mid-operation: all contents are logically discarded at once and outputs take their reset values. There is no recovery of in-flight flits.
- Every output is registered or a decode of registers, with one exception: rd_data in FWFT=1 mode is a registered-pointer mux of the array. No output has a combinational path from inputs.

Decomposition:
- Shared package noc_pkg holds FLIT_W=16 and typedef logic [FLIT_W-1:0] flit_t. The router top-level uses these to set DATA_W.
- One sub-module, noc_fifo_ptr (parameter DEPTH), provides the wrapping pointer register with an increment enable. It is instantiated twice, once for wr_ptr and once for rd_ptr.
- Storage array, count logic and flags stay inline.

Test Plan:
- DEPTH=5, FWFT=0: push 0xA001..0xA005, then pop 5 times -> full=1 after the 5th push; rd_data is 0xA001..0xA005 in order, each one cycle after rd_en; empty=1 and count=0 at the end.
- DEPTH=5, AF_LEVEL=4: push 4 flits -> almost_full rises on the edge after the 4th push with count=4, full=0; a 5th push gives full=1; a 6th push with rd_en=0 sets overflow, count stays 5, contents unchanged.
- Full FIFO, wr_en=rd_en=1 for 7 cycles with data 0xB000+i -> count stays 5; pointers wrap through 4->0; pops return the 5 original flits followed by 0xB000, 0xB001; overflow stays 0.
- Empty FIFO, wr_en=rd_en=1 with 0xC0DE -> underflow=1, count=1, rd_valid=0; the next pop returns 0xC0DE. clr_err=1 for one cycle then clears underflow to 0.
- FWFT=1, DEPTH=3: push 0x1111 -> rd_data=0x1111 and rd_valid=1 the next cycle; pop with a concurrent push of 0x2222 -> rd_data=0x2222 the next cycle, count=1.
- Push 3 flits, then drive rst_n low asynchronously between edges -> count=0, empty=1, rd_valid=0 and flags=0 immediately; after release, pops flag underflow.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router types.
// Flit width used by the router top-level to size its input buffers.
package noc_pkg;
  localparam int FLIT_W = 16;
  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/noc_fifo_ptr.sv
// Wrapping FIFO pointer for arbitrary (non power-of-two) depth.
// Wraps from DEPTH-1 to 0 when inc_i is high.
module noc_fifo_ptr #(
  parameter int DEPTH = 5,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/noc_flit_fifo.sv
// Router input-port flit FIFO with count, almost-full,
// optional FWFT read and sticky overflow/underflow flags.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int DATA_W   = FLIT_W,
  parameter int DEPTH    = 5,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int FWFT     = 0,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  // A pop from a full FIFO frees the slot the same-cycle push uses.
  assign pop_ok  = rd_en && !empty;
  assign push_ok = wr_en && (!full || pop_ok);

  always_comb begin
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    ovf_d   = (ovf_q && !clr_err) || (wr_en && !push_ok);
    unf_d   = (unf_q && !clr_err) || (rd_en && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  noc_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (push_ok),
    .ptr_o (wr_ptr)
  );

  noc_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  generate
    if (FWFT == 0) begin : g_reg_rd
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= pop_ok;
          if (pop_ok) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft_rd
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !empty;
    end
  endgenerate

endmodule
